// File: rtl/ddr2_ctrl_input_if.sv
// ddr2_ctrl_input_if: write command, user FIFO read port and DDR2 local write bus (wr_size_err only with DDR2_WR_SIZE_CHK_EN)
interface ddr2_ctrl_input_if #(parameter int ADDR_W = 24, parameter int SIZE_W = 7);
  logic              wr_cmd_valid;
  logic              wr_cmd_ready;
  logic [ADDR_W-1:0] wr_cmd_addr;
  logic [SIZE_W-1:0] wr_cmd_size;
  logic              wr_done;
  logic              um2ddr_empty;
  logic [127:0]      um2ddr_data;
  logic              um2ddr_rdreq;
  logic              local_init_done;
  logic              local_ready;
  logic              local_write_req;
  logic              local_burstbegin;
  logic [ADDR_W-1:0] local_address;
  logic [2:0]        local_size;
  logic [3:0]        local_be;
  logic [31:0]       local_wdata;
`ifdef DDR2_WR_SIZE_CHK_EN
  logic              wr_size_err;
`endif
  modport master (
`ifdef DDR2_WR_SIZE_CHK_EN
    output wr_size_err,
`endif
    input  wr_cmd_valid, wr_cmd_addr, wr_cmd_size, um2ddr_empty, um2ddr_data, local_init_done, local_ready,
    output wr_cmd_ready, wr_done, um2ddr_rdreq, local_write_req, local_burstbegin, local_address,
           local_size, local_be, local_wdata
  );
  modport slave (
`ifdef DDR2_WR_SIZE_CHK_EN
    input  wr_size_err,
`endif
    output wr_cmd_valid, wr_cmd_addr, wr_cmd_size, um2ddr_empty, um2ddr_data, local_init_done, local_ready,
    input  wr_cmd_ready, wr_done, um2ddr_rdreq, local_write_req, local_burstbegin, local_address,
           local_size, local_be, local_wdata
  );
endinterface

// File: rtl/ddr2_ctrl_input.sv
// ddr2_ctrl_input: serialises 128-bit FIFO words into 4-beat 32-bit DDR2 write bursts; DDR2_WR_SIZE_CHK_EN adds sticky wr_size_err
module ddr2_ctrl_input #(
  parameter int ADDR_W    = 24,
  parameter int SIZE_W    = 7,
  parameter int ADDR_STEP = 4
) (
  input logic             sys_rst_n,
  input logic             ddr2_clk,
  ddr2_ctrl_input_if.master bus
);
  localparam int WW = SIZE_W - 2;
  typedef enum logic [1:0] {IDLE, FETCH, BURST, DONE} state_t;
  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [WW-1:0]     words;
  logic [127:0]      shreg;
  logic [1:0]        beat;
  logic              accept;
  logic [WW-1:0]     cmd_words;
  logic              skip;
  assign accept    = bus.wr_cmd_valid & bus.wr_cmd_ready;
  assign cmd_words = bus.wr_cmd_size[SIZE_W-1:2];
`ifdef DDR2_WR_SIZE_CHK_EN
  logic size_bad;
  assign size_bad = (|bus.wr_cmd_size[1:0]) | (cmd_words == '0);
  assign skip     = size_bad;
`else
  logic unused_size_lsbs;
  assign unused_size_lsbs = ^bus.wr_cmd_size[1:0];
  assign skip             = cmd_words == '0;
`endif
  assign bus.local_size = 3'd4;
  assign bus.local_be   = 4'hF;
  // command FSM with all handshake and bus outputs registered; ready tracks the next state being IDLE
  always_ff @(posedge ddr2_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state                <= IDLE;
      addr                 <= '0;
      words                <= '0;
      shreg                <= '0;
      beat                 <= '0;
      bus.wr_cmd_ready     <= 1'b0;
      bus.wr_done          <= 1'b0;
      bus.um2ddr_rdreq     <= 1'b0;
      bus.local_write_req  <= 1'b0;
      bus.local_burstbegin <= 1'b0;
      bus.local_address    <= '0;
      bus.local_wdata      <= '0;
`ifdef DDR2_WR_SIZE_CHK_EN
      bus.wr_size_err      <= 1'b0;
`endif
    end else begin
      bus.wr_done      <= 1'b0;
      bus.um2ddr_rdreq <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            addr             <= bus.wr_cmd_addr;
            words            <= cmd_words;
            bus.wr_cmd_ready <= 1'b0;
            bus.wr_done      <= skip;
            state            <= skip ? DONE : FETCH;
`ifdef DDR2_WR_SIZE_CHK_EN
            if (size_bad) bus.wr_size_err <= 1'b1;
`endif
          end else begin
            bus.wr_cmd_ready <= 1'b1;
          end
        end
        FETCH: begin
          if (bus.local_init_done && !bus.um2ddr_empty) begin
            bus.um2ddr_rdreq     <= 1'b1;
            shreg                <= bus.um2ddr_data;
            bus.local_wdata      <= bus.um2ddr_data[127:96];
            bus.local_burstbegin <= 1'b1;
            bus.local_write_req  <= 1'b1;
            bus.local_address    <= addr;
            beat                 <= 2'd0;
            state                <= BURST;
          end
        end
        BURST: begin
          if (bus.local_ready) begin
            beat                 <= beat + 2'd1;
            shreg                <= {shreg[95:0], 32'h0};
            bus.local_wdata      <= shreg[95:64];
            bus.local_burstbegin <= 1'b0;
            if (beat == 2'd3) begin
              bus.local_write_req <= 1'b0;
              words               <= words - WW'(1);
              addr                <= addr + ADDR_W'(ADDR_STEP);
              bus.wr_done         <= words == WW'(1);
              state               <= (words == WW'(1)) ? DONE : FETCH;
            end
          end
        end
        DONE: begin
          bus.wr_cmd_ready <= 1'b1;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ddr2_ctrl_input.sv
// tb_ddr2_ctrl_input: scoreboard bench with a word-level reference model of the DDR2 write input path
module tb_ddr2_ctrl_input;
`ifdef DDR2_WR_SIZE_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  typedef struct {logic [23:0] a; logic [31:0] d; logic bb;} beat_t;
  typedef struct {int beats; int pops; logic err;} done_t;
  logic ddr2_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 ddr2_clk = ~ddr2_clk;
  ddr2_ctrl_input_if bus();
  ddr2_ctrl_input dut (.sys_rst_n(sys_rst_n), .ddr2_clk(ddr2_clk), .bus(bus.master));
  beat_t        exp_beats[$];
  done_t        exp_done[$];
  logic [127:0] fifo_q[$];
  logic [127:0] later_q[$];
  int tests = 0, fails = 0;
  int beat_cnt = 0, pop_cnt = 0, req_cycles = 0;
  logic hold_empty = 1'b0, ready_low = 1'b0, rand_rdy = 1'b0, mon_en = 1'b0, err_model = 1'b0;
  logic [31:0] h_d;
  logic [23:0] h_a;
  logic        h_bb, h_v = 1'b0;
  beat_t e;
  done_t de;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // environment drivers: FIFO head/empty and local_ready change just after each rising edge
  always @(posedge ddr2_clk) begin
    #1;
    bus.local_ready  = ready_low ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
    bus.um2ddr_empty = hold_empty || fifo_q.size() == 0;
    bus.um2ddr_data  = fifo_q.size() != 0 ? fifo_q[0] : 128'h0;
  end

  // monitor: pops the scoreboard for each accepted beat, FIFO pop and completion
  always @(negedge ddr2_clk) begin
    if (mon_en) begin
      if (h_v && bus.local_write_req) begin
        check("hold_wdata", 128'(bus.local_wdata), 128'(h_d));
        check("hold_addr", 128'(bus.local_address), 128'(h_a));
        check("hold_bb", 128'(bus.local_burstbegin), 128'(h_bb));
      end
      h_v  = bus.local_write_req & ~bus.local_ready;
      h_d  = bus.local_wdata;
      h_a  = bus.local_address;
      h_bb = bus.local_burstbegin;
      if (bus.local_write_req) req_cycles++;
      if (bus.local_write_req && bus.local_ready) begin
        if (exp_beats.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_beat: got wdata %0h expected no beat", bus.local_wdata);
        end else begin
          e = exp_beats.pop_front();
          check("wdata", 128'(bus.local_wdata), 128'(e.d));
          check("address", 128'(bus.local_address), 128'(e.a));
          check("burstbegin", 128'(bus.local_burstbegin), 128'(e.bb));
        end
        beat_cnt++;
      end
      if (bus.um2ddr_rdreq) begin
        if (fifo_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL pop_empty: got rdreq 1 expected 0 on empty FIFO");
        end else void'(fifo_q.pop_front());
        pop_cnt++;
      end
      if (bus.wr_done) begin
        if (exp_done.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got wr_done 1 expected 0");
        end else begin
          de = exp_done.pop_front();
          check("done_beats", 128'(beat_cnt), 128'(de.beats));
          check("done_pops", 128'(pop_cnt), 128'(de.pops));
`ifdef DDR2_WR_SIZE_CHK_EN
          check("size_err", 128'(bus.wr_size_err), 128'(de.err));
`endif
        end
        beat_cnt = 0;
        pop_cnt  = 0;
      end
    end
  end

  // reference model: size/4 words, beat b of word w = word[127-32b -: 32] at addr + 4w (mod 2^24)
  task automatic issue(input logic [23:0] a, input int size, input int nfifo, input logic [127:0] first, input bit fixed);
    bit bad;
    int n;
    logic [127:0] word;
    bad = CHK && (size % 4 != 0 || size == 0);
    n   = bad ? 0 : size / 4;
    err_model |= bad;
    for (int w = 0; w < n; w++) begin
      word = (fixed && w == 0) ? first : {$urandom, $urandom, $urandom, $urandom};
      for (int b = 0; b < 4; b++)
        exp_beats.push_back('{a: 24'(a + 4 * w), d: word[127 - 32 * b -: 32], bb: b == 0});
      if (w < nfifo) fifo_q.push_back(word);
      else later_q.push_back(word);
    end
    exp_done.push_back('{beats: n * 4, pops: n, err: err_model});
    for (int i = 0; i < 200 && !bus.wr_cmd_ready; i++) @(negedge ddr2_clk);
    check("cmd_ready_timeout", 128'(bus.wr_cmd_ready), 128'(1));
    bus.wr_cmd_valid = 1'b1;
    bus.wr_cmd_addr  = a;
    bus.wr_cmd_size  = 7'(size);
    @(posedge ddr2_clk);
    #1;
    bus.wr_cmd_valid = 1'b0;
    @(negedge ddr2_clk);
    check("first_cycle_no_req", 128'(bus.local_write_req), 128'(0));
    check("ready_after_accept", 128'(bus.wr_cmd_ready), 128'(0));
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 3000 && exp_done.size() != 0; i++) @(negedge ddr2_clk);
    check("done_timeout", 128'(exp_done.size()), 128'(0));
    exp_done.delete();
    exp_beats.delete();
  endtask

  task automatic wait_beats(input int n);
    for (int i = 0; i < 500 && beat_cnt < n; i++) @(negedge ddr2_clk);
    check("beat_wait_timeout", 128'(beat_cnt >= n), 128'(1));
  endtask

  task automatic check_reset_vals();
    check("rst_cmd_ready", 128'(bus.wr_cmd_ready), 128'(0));
    check("rst_done", 128'(bus.wr_done), 128'(0));
    check("rst_rdreq", 128'(bus.um2ddr_rdreq), 128'(0));
    check("rst_write_req", 128'(bus.local_write_req), 128'(0));
    check("rst_burstbegin", 128'(bus.local_burstbegin), 128'(0));
    check("rst_address", 128'(bus.local_address), 128'(0));
    check("rst_wdata", 128'(bus.local_wdata), 128'(0));
    check("rst_size", 128'(bus.local_size), 128'(4));
    check("rst_be", 128'(bus.local_be), 128'(4'hF));
`ifdef DDR2_WR_SIZE_CHK_EN
    check("rst_size_err", 128'(bus.wr_size_err), 128'(0));
`endif
  endtask

  initial begin
    int snap;
    logic [23:0] ra;
    bus.wr_cmd_valid    = 1'b0;
    bus.wr_cmd_addr     = '0;
    bus.wr_cmd_size     = '0;
    bus.local_init_done = 1'b1;
    repeat (2) @(negedge ddr2_clk);
    check_reset_vals();
    sys_rst_n = 1'b1;
    mon_en    = 1'b1;
    // single burst with a known word
    issue(24'h000100, 4, 1, 128'h11111111_22222222_33333333_44444444, 1'b1);
    wait_done();
    // four bursts back to back, with wr_cmd_valid noise while busy
    issue(24'h000100, 16, 4, 128'h0, 1'b0);
    bus.wr_cmd_valid = 1'b1;
    bus.wr_cmd_addr  = 24'hABCDEF;
    bus.wr_cmd_size  = 7'd8;
    repeat (3) @(negedge ddr2_clk);
    bus.wr_cmd_valid = 1'b0;
    wait_done();
    // local_ready held low for 5 cycles on beat 2
    issue(24'h000400, 8, 2, 128'h0, 1'b0);
    wait_beats(2);
    ready_low = 1'b1;
    repeat (5) @(posedge ddr2_clk);
    ready_low = 1'b0;
    wait_done();
    // init_done low blocks first fetch, then FIFO empty after word 1 of 2
    bus.local_init_done = 1'b0;
    issue(24'h000100, 8, 1, 128'h0, 1'b0);
    snap = req_cycles;
    repeat (10) @(negedge ddr2_clk);
    check("init_blocks_fetch", 128'(req_cycles - snap), 128'(0));
    bus.local_init_done = 1'b1;
    wait_beats(4);
    repeat (2) @(negedge ddr2_clk);
    snap = req_cycles;
    repeat (20) @(negedge ddr2_clk);
    check("empty_stalls_fetch", 128'(req_cycles - snap), 128'(0));
    while (later_q.size() != 0) fifo_q.push_back(later_q.pop_front());
    wait_done();
    // reset in the middle of a burst, then a fresh command
    issue(24'h000200, 16, 4, 128'h0, 1'b0);
    wait_beats(6);
    #2;
    sys_rst_n = 1'b0;
    mon_en    = 1'b0;
    #1;
    check_reset_vals();
    exp_beats.delete();
    exp_done.delete();
    fifo_q.delete();
    later_q.delete();
    beat_cnt  = 0;
    pop_cnt   = 0;
    err_model = 1'b0;
    h_v       = 1'b0;
    repeat (3) @(posedge ddr2_clk);
    @(negedge ddr2_clk);
    sys_rst_n = 1'b1;
    mon_en    = 1'b1;
    issue(24'h000300, 4, 1, 128'h0, 1'b0);
    wait_done();
    // size not a multiple of 4: rounded down, or flagged and dropped when checking is enabled
    issue(24'h000500, 6, 2, 128'h0, 1'b0);
    wait_done();
    issue(24'h000600, 4, 1, 128'h0, 1'b0);
    wait_done();
`ifdef DDR2_WR_SIZE_CHK_EN
    check("size_err_sticky", 128'(bus.wr_size_err), 128'(1));
`endif
    // randomized commands, random local_ready, including address wrap
    rand_rdy = 1'b1;
    for (int k = 0; k < 30; k++) begin
      ra = ($urandom_range(0, 3) == 0) ? 24'hFFFFF8 : 24'($urandom);
      issue(ra, $urandom_range(0, 20), 8, 128'h0, 1'b0);
      wait_done();
    end
    rand_rdy = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
